// File: rtl/adc_spi_pkg.sv
// Shared types and constants for the MCP3202 SPI responder model.
package adc_spi_pkg;

    localparam int unsigned ADC_DATA_BITS = 12;

    // Command bits in the order they arrive on mosi.
    typedef enum int unsigned {
        CMD_START,
        CMD_SGL,
        CMD_ODD,
        CMD_MSBF
    } cmd_bit_t;

    localparam logic NULL_BIT_LEVEL = 1'b0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_GET_SGL,
        ST_GET_ODD,
        ST_GET_MSBF,
        ST_NULL_BIT,
        ST_DATA_MSB,
        ST_DATA_LSB,
        ST_DONE
    } state_t;

    // States in which a chip-select release counts as an aborted frame.
    function automatic logic in_frame(state_t s);
        return s inside {ST_GET_SGL, ST_GET_ODD, ST_GET_MSBF, ST_NULL_BIT,
                         ST_DATA_MSB, ST_DATA_LSB};
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer for one asynchronous SPI line with registered
// rise/fall detection; level is delayed to line up with the edge pulses.
module spi_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync  <= {SYNC_STAGES{RESET_LEVEL}};
            level <= RESET_LEVEL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], din};
            level <= sync[SYNC_STAGES-2];
            rise  <= sync[SYNC_STAGES-2] & ~sync[SYNC_STAGES-1];
            fall  <= ~sync[SYNC_STAGES-2] & sync[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/adc_spi_responder.sv
// Cycle-level MCP3202 SPI slave: decodes start/SGL/ODD/MSBF on mosi and
// returns a null bit plus the selected channel value on miso.
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int unsigned DATA_BITS   = ADC_DATA_BITS,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        MISO_IDLE   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cs_n,
    input  logic                 sclk,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 miso_oe,
    input  logic [DATA_BITS-1:0] ch0_value,
    input  logic [DATA_BITS-1:0] ch1_value,
    output logic                 cmd_sgl,
    output logic                 cmd_odd,
    output logic                 frame_done,
    output logic                 frame_abort
);

    localparam int unsigned          CNT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]     LAST  = CNT_W'(DATA_BITS - 1);

    logic cs_rise, cs_fall, cs_level_unused;
    logic sclk_rise, sclk_fall, sclk_level_unused;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_cs_sync (
        .clk(clk), .rst(rst), .din(cs_n),
        .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sclk_sync (
        .clk(clk), .rst(rst), .din(sclk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_mosi_sync (
        .clk(clk), .rst(rst), .din(mosi),
        .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [DATA_BITS-1:0] value, value_n;
    logic                 msbf, msbf_n;
    logic                 miso_n, oe_n, sgl_n, odd_n, done_n, abort_n;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            value       <= '0;
            msbf        <= 1'b0;
            miso        <= MISO_IDLE;
            miso_oe     <= 1'b0;
            cmd_sgl     <= 1'b0;
            cmd_odd     <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            value       <= value_n;
            msbf        <= msbf_n;
            miso        <= miso_n;
            miso_oe     <= oe_n;
            cmd_sgl     <= sgl_n;
            cmd_odd     <= odd_n;
            frame_done  <= done_n;
            frame_abort <= abort_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        value_n = value;
        msbf_n  = msbf;
        miso_n  = miso;
        oe_n    = miso_oe;
        sgl_n   = cmd_sgl;
        odd_n   = cmd_odd;
        done_n  = 1'b0;
        abort_n = 1'b0;
        // Chip-select release takes priority; any sclk edge in the same clock is dropped.
        if (cs_rise) begin
            state_n = ST_IDLE;
            oe_n    = 1'b0;
            miso_n  = MISO_IDLE;
            abort_n = in_frame(state);
        end else begin
            unique case (state)
                ST_IDLE: if (cs_fall) state_n = ST_WAIT_START;
                ST_WAIT_START: if (sclk_rise && mosi_level) state_n = ST_GET_SGL;
                ST_GET_SGL: if (sclk_rise) begin
                    sgl_n   = mosi_level;
                    state_n = ST_GET_ODD;
                end
                ST_GET_ODD: if (sclk_rise) begin
                    odd_n   = mosi_level;
                    state_n = ST_GET_MSBF;
                end
                ST_GET_MSBF: if (sclk_rise) begin
                    msbf_n  = mosi_level;
                    value_n = cmd_odd ? ch1_value : ch0_value;
                    state_n = ST_NULL_BIT;
                end
                ST_NULL_BIT: if (sclk_fall) begin
                    miso_n  = NULL_BIT_LEVEL;
                    oe_n    = 1'b1;
                    cnt_n   = LAST;
                    state_n = ST_DATA_MSB;
                end
                ST_DATA_MSB: if (sclk_fall) begin
                    miso_n = value[cnt];
                    if (cnt == '0) begin
                        if (msbf) begin
                            state_n = ST_DONE;
                            done_n  = 1'b1;
                        end else begin
                            state_n = ST_DATA_LSB;
                            cnt_n   = CNT_W'(1);
                        end
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                ST_DATA_LSB: if (sclk_fall) begin
                    miso_n = value[cnt];
                    if (cnt == LAST) begin
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                ST_DONE: if (sclk_fall) miso_n = 1'b0;
                default: state_n = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Self-checking bench for adc_spi_responder: directed table frames, abort and
// reset corner cases, and random frames against a bit-sequence model.
module tb_adc_spi_responder;

    logic        clk, rst, cs_n, sclk, mosi;
    logic        miso, miso_oe, cmd_sgl, cmd_odd, frame_done, frame_abort;
    logic [11:0] ch0_value, ch1_value;

    int unsigned checks = 0, failures = 0, done_cnt = 0, abort_cnt = 0;

    adc_spi_responder #(.DATA_BITS(12), .SYNC_STAGES(2), .MISO_IDLE(1'b1)) dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .sclk(sclk), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe),
        .ch0_value(ch0_value), .ch1_value(ch1_value),
        .cmd_sgl(cmd_sgl), .cmd_odd(cmd_odd),
        .frame_done(frame_done), .frame_abort(frame_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done)  done_cnt++;
        if (frame_abort) abort_cnt++;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        sgl, odd, msbf;
        int unsigned lead, half;
        logic [11:0] c0, c1, n0, n1;
        logic        exp_sgl, exp_odd;
        logic [11:0] exp_val;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected miso for the k-th sclk fall counted from the null bit.
    function automatic logic exp_bit(input logic [11:0] v, input logic msbf, input int unsigned k);
        if (k == 0) return 1'b0;
        if (k <= 12) return v[4'(12 - k)];
        if (!msbf && k <= 23) return v[4'(k - 12)];
        return 1'b0;
    endfunction

    function automatic logic cmd_bit(input int unsigned i, input int unsigned lead,
                                     input logic sgl, input logic odd, input logic msbf);
        if (i < lead)      return 1'b0;
        if (i == lead)     return 1'b1;
        if (i == lead + 1) return sgl;
        if (i == lead + 2) return odd;
        if (i == lead + 3) return msbf;
        return 1'($urandom_range(1, 0));
    endfunction

    // mode 0: full frame, 1: cs_n abort after stop falls, 2: reset after stop falls
    task automatic run_frame(input string name, input logic sgl, input logic odd, input logic msbf,
                             input int unsigned lead, input int unsigned half,
                             input logic [11:0] c0, input logic [11:0] c1,
                             input logic [11:0] n0, input logic [11:0] n1,
                             input int unsigned stop, input int unsigned mode,
                             input logic exp_sgl, input logic exp_odd, input logic [11:0] exp_val);
        int unsigned d0, a0, nf, ncyc, k;
        ch0_value = c0;
        ch1_value = c1;
        d0 = done_cnt;
        a0 = abort_cnt;
        nf = (mode != 0) ? stop : (msbf ? 15 : 26);
        ncyc = lead + 3 + nf;
        mosi = cmd_bit(0, lead, sgl, odd, msbf);
        cs_n = 1'b0;
        wait_clks(half);
        for (int unsigned i = 0; i < ncyc; i++) begin
            sclk = 1'b1;
            wait_clks(half);
            sclk = 1'b0;
            wait_clks(half / 2);
            mosi = cmd_bit(i + 1, lead, sgl, odd, msbf);
            wait_clks(half - half / 2);
            if (i < lead + 3) begin
                check($sformatf("%s.cmd%0d", name, i), 32'({miso_oe, miso}), 32'(2'b01));
            end else begin
                k = i - (lead + 3);
                check($sformatf("%s.bit%0d", name, k), 32'({miso_oe, miso}),
                      32'({1'b1, exp_bit(exp_val, msbf, k)}));
            end
            if (i == lead + 3) begin
                ch0_value = n0;
                ch1_value = n1;
            end
        end
        if (mode == 0) begin
            cs_n = 1'b1;
            wait_clks(8);
            check({name, ".idle"}, 32'({miso_oe, miso}), 32'(2'b01));
            check({name, ".done"}, done_cnt - d0, 1);
            check({name, ".noabort"}, abort_cnt - a0, 0);
            check({name, ".sgl"}, 32'(cmd_sgl), 32'(exp_sgl));
            check({name, ".odd"}, 32'(cmd_odd), 32'(exp_odd));
        end else if (mode == 1) begin
            cs_n = 1'b1;
            wait_clks(3);
            check({name, ".oe_off"}, 32'({miso_oe, miso}), 32'(2'b01));
            wait_clks(5);
            check({name, ".abort"}, abort_cnt - a0, 1);
            check({name, ".nodone"}, done_cnt - d0, 0);
            check({name, ".sgl_hold"}, 32'(cmd_sgl), 32'(exp_sgl));
            check({name, ".odd_hold"}, 32'(cmd_odd), 32'(exp_odd));
        end else begin
            rst = 1'b0;
            wait_clks(1);
            check({name, ".rst_miso"}, 32'({miso_oe, miso}), 32'(2'b01));
            check({name, ".rst_cmd"}, 32'({cmd_sgl, cmd_odd}), 32'(2'b00));
            wait_clks(2);
            rst = 1'b1;
            cs_n = 1'b1;
            wait_clks(8);
            check({name, ".post_miso"}, 32'({miso_oe, miso}), 32'(2'b01));
            check({name, ".nodone"}, done_cnt - d0, 0);
            check({name, ".noabort"}, abort_cnt - a0, 0);
        end
    endtask

    initial begin
        logic        s, o, m;
        logic [11:0] r0, r1, q0, q1;

        rst = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        ch0_value = '0; ch1_value = '0;

        vecs[0] = '{1'b1, 1'b0, 1'b1, 0, 250, 12'hA5C, 12'h0F0, 12'hA5C, 12'h0F0, 1'b1, 1'b0, 12'hA5C};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 0, 20,  12'h3C3, 12'h801, 12'h3C3, 12'h801, 1'b1, 1'b1, 12'h801};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 3, 20,  12'hA5C, 12'h0F0, 12'hA5C, 12'h0F0, 1'b1, 1'b0, 12'hA5C};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1, 20,  12'h000, 12'hFFF, 12'h000, 12'hFFF, 1'b0, 1'b1, 12'hFFF};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 0, 20,  12'h123, 12'h456, 12'hFFF, 12'h456, 1'b1, 1'b0, 12'h123};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 2, 20,  12'hFFF, 12'h456, 12'hFFF, 12'h456, 1'b1, 1'b0, 12'hFFF};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 0, 20,  12'h555, 12'hAAA, 12'h000, 12'hFFF, 1'b0, 1'b0, 12'h555};

        wait_clks(3);
        check("reset.miso", 32'({miso_oe, miso}), 32'(2'b01));
        check("reset.cmd", 32'({cmd_sgl, cmd_odd}), 32'(2'b00));
        check("reset.pulses", 32'({frame_done, frame_abort}), 32'(2'b00));
        rst = 1'b1;
        wait_clks(4);

        for (int unsigned t = 0; t < 7; t++) begin
            run_frame($sformatf("vec%0d", t), vecs[t].sgl, vecs[t].odd, vecs[t].msbf,
                      vecs[t].lead, vecs[t].half, vecs[t].c0, vecs[t].c1, vecs[t].n0, vecs[t].n1,
                      0, 0, vecs[t].exp_sgl, vecs[t].exp_odd, vecs[t].exp_val);
            wait_clks(10);
        end

        run_frame("abort", 1'b0, 1'b1, 1'b1, 0, 20, 12'h111, 12'hABC, 12'h111, 12'hABC,
                  6, 1, 1'b0, 1'b1, 12'hABC);
        wait_clks(10);
        run_frame("midreset", 1'b1, 1'b1, 1'b0, 1, 20, 12'h111, 12'hC3A, 12'h111, 12'hC3A,
                  4, 2, 1'b1, 1'b1, 12'hC3A);
        wait_clks(10);
        run_frame("after_reset", 1'b1, 1'b0, 1'b1, 0, 20, 12'hA5C, 12'h0F0, 12'hA5C, 12'h0F0,
                  0, 0, 1'b1, 1'b0, 12'hA5C);
        wait_clks(10);

        for (int unsigned t = 0; t < 12; t++) begin
            s  = 1'($urandom_range(1, 0));
            o  = 1'($urandom_range(1, 0));
            m  = 1'($urandom_range(1, 0));
            r0 = 12'($urandom);
            r1 = 12'($urandom);
            q0 = 12'($urandom);
            q1 = 12'($urandom);
            run_frame($sformatf("rand%0d", t), s, o, m, $urandom_range(3, 0), $urandom_range(24, 8),
                      r0, r1, q0, q1, 0, 0, s, o, o ? r1 : r0);
            wait_clks($urandom_range(12, 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
